// File: rtl/arm_cpu_axi_ctrl_if.sv
// AXI4-Lite bundle between the host-side master and the ARM CPU control slave.
// Handshake rule for every channel: a beat transfers on the rising clock edge
// where VALID and READY are both high. Once VALID is raised, the source holds
// it and its payload stable until that edge.
interface arm_cpu_axi_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/arm_cpu_axi_ctrl.sv
// AXI4-Lite control slave for the single-cycle ARM CPU: run/step/core-reset
// control, a word-addressed IMEM load window and PC/halt status.
// Optional feature macro: ARM_CTRL_CYCLE_CNT_EN adds a 32-bit run-cycle
// counter at 0x18. Without it, 0x18 reads 0 and has no flops.
module arm_cpu_axi_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int IMEM_AW            = 10
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  arm_cpu_axi_ctrl_if.slave  s_axi,
  output logic               cpu_run,
  output logic               cpu_rst_n,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  input  logic [31:0]        cpu_pc,
  input  logic               cpu_halted
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_IMEM_ADDR = 3'd1;
  localparam logic [2:0] REG_IMEM_DATA = 3'd2;
  localparam logic [2:0] REG_STATUS    = 3'd3;
  localparam logic [2:0] REG_PC        = 3'd4;
  localparam logic [2:0] REG_SCRATCH   = 3'd5;
  localparam logic [2:0] REG_CYCLE     = 3'd6;

  // Write channel holding state and payload
  logic          aw_held, w_held;
  logic [2:0]    aw_idx;
  logic [DW-1:0] wdata_q;
  logic [3:0]    wstrb_q;
  logic [DW-1:0] wmask, wdata_m;

  // Programmer-visible state
  logic               run_q, step_pulse, rst_pend;
  logic [DW-1:0]      scratch, imem_last, rd_mux, cycle_rd;
  logic [IMEM_AW-1:0] imem_addr;

  logic do_write, ctrl_wr, core_rst_wr, wr_ok;
  logic unused_bits;

  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  assign do_write    = aw_held & w_held;
  assign ctrl_wr     = do_write && (aw_idx == REG_CTRL) && wstrb_q[0];
  assign core_rst_wr = ctrl_wr && wdata_q[1];
  assign wr_ok       = (aw_idx == REG_CTRL) || (aw_idx == REG_IMEM_ADDR) ||
                       (aw_idx == REG_IMEM_DATA) || (aw_idx == REG_SCRATCH);
  assign cpu_run     = run_q | step_pulse;
  assign s_axi.S_AXI_RRESP = RESP_OKAY;

  // Expand byte strobes into a bit mask; unset bytes read as zero
  always_comb begin
    wmask = '0;
    for (int i = 0; i < DW / 8; i++) wmask[8*i +: 8] = {8{wstrb_q[i]}};
    wdata_m = wdata_q & wmask;
  end

  // AW/W acceptance, register update and write response
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s_axi.S_AXI_AWREADY <= 1'b0;
      s_axi.S_AXI_WREADY  <= 1'b0;
      s_axi.S_AXI_BVALID  <= 1'b0;
      s_axi.S_AXI_BRESP   <= RESP_OKAY;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_idx     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      run_q      <= 1'b0;
      step_pulse <= 1'b0;
      rst_pend   <= 1'b1;
      cpu_rst_n  <= 1'b0;
      scratch    <= '0;
      imem_last  <= '0;
      imem_addr  <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      // AWREADY is a one-cycle pulse; nothing new is taken while B is pending
      if (s_axi.S_AXI_AWREADY && s_axi.S_AXI_AWVALID) begin
        s_axi.S_AXI_AWREADY <= 1'b0;
        aw_held <= 1'b1;
        aw_idx  <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end else if (!s_axi.S_AXI_AWREADY && !aw_held && !s_axi.S_AXI_BVALID &&
                   s_axi.S_AXI_AWVALID) begin
        s_axi.S_AXI_AWREADY <= 1'b1;
      end
      if (s_axi.S_AXI_WREADY && s_axi.S_AXI_WVALID) begin
        s_axi.S_AXI_WREADY <= 1'b0;
        w_held  <= 1'b1;
        wdata_q <= s_axi.S_AXI_WDATA;
        wstrb_q <= s_axi.S_AXI_WSTRB;
      end else if (!s_axi.S_AXI_WREADY && !w_held && !s_axi.S_AXI_BVALID &&
                   s_axi.S_AXI_WVALID) begin
        s_axi.S_AXI_WREADY <= 1'b1;
      end

      if (do_write) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        s_axi.S_AXI_BVALID <= 1'b1;
        s_axi.S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi.S_AXI_BVALID && s_axi.S_AXI_BREADY) begin
        s_axi.S_AXI_BVALID <= 1'b0;
      end

      // RUN: core reset wins, then a host write, then halt clears it
      if (core_rst_wr)   run_q <= 1'b0;
      else if (ctrl_wr)  run_q <= wdata_q[0];
      else if (cpu_halted) run_q <= 1'b0;
      step_pulse <= ctrl_wr && !wdata_q[1] && wdata_q[2] && !run_q && !cpu_halted;

      // Core reset: low for the write cycle plus one more; rewrites restart it
      if (core_rst_wr) begin
        rst_pend  <= 1'b1;
        cpu_rst_n <= 1'b0;
      end else if (rst_pend) begin
        rst_pend  <= 1'b0;
      end else begin
        cpu_rst_n <= 1'b1;
      end

      imem_we <= 1'b0;
      if (do_write && aw_idx == REG_IMEM_DATA) begin
        imem_we    <= 1'b1;
        imem_waddr <= imem_addr;
        imem_wdata <= wdata_m;
        imem_last  <= wdata_m;
        imem_addr  <= imem_addr + 1'b1;
      end else if (do_write && aw_idx == REG_IMEM_ADDR) begin
        imem_addr <= (imem_addr & ~wmask[IMEM_AW-1:0]) | wdata_m[IMEM_AW-1:0];
      end
      if (do_write && aw_idx == REG_SCRATCH)
        scratch <= (scratch & ~wmask) | wdata_m;
    end
  end

`ifdef ARM_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
  // Count cycles the core is enabled; cleared by a core reset write
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)         cycle_cnt <= '0;
    else if (core_rst_wr) cycle_cnt <= '0;
    else if (cpu_run)     cycle_cnt <= cycle_cnt + 32'd1;
  end
  assign cycle_rd = cycle_cnt;
`else
  assign cycle_rd = '0;
`endif

  // Read data selection from current (pre-write) register values
  always_comb begin
    rd_mux = '0;
    case (s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2])
      REG_CTRL:      rd_mux = {{(DW-1){1'b0}}, run_q};
      REG_IMEM_ADDR: rd_mux = {{(DW-IMEM_AW){1'b0}}, imem_addr};
      REG_IMEM_DATA: rd_mux = imem_last;
      REG_STATUS:    rd_mux = {{(DW-2){1'b0}}, cpu_halted, cpu_run};
      REG_PC:        rd_mux = cpu_pc;
      REG_SCRATCH:   rd_mux = scratch;
      REG_CYCLE:     rd_mux = cycle_rd;
      default:       rd_mux = '0;
    endcase
  end

  // AR accept pulse, registered read data held until RREADY
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s_axi.S_AXI_ARREADY <= 1'b0;
      s_axi.S_AXI_RVALID  <= 1'b0;
      s_axi.S_AXI_RDATA   <= '0;
    end else begin
      if (s_axi.S_AXI_ARREADY && s_axi.S_AXI_ARVALID) begin
        s_axi.S_AXI_ARREADY <= 1'b0;
        s_axi.S_AXI_RVALID  <= 1'b1;
        s_axi.S_AXI_RDATA   <= rd_mux;
      end else begin
        if (!s_axi.S_AXI_ARREADY && !s_axi.S_AXI_RVALID && s_axi.S_AXI_ARVALID)
          s_axi.S_AXI_ARREADY <= 1'b1;
        if (s_axi.S_AXI_RVALID && s_axi.S_AXI_RREADY)
          s_axi.S_AXI_RVALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_arm_cpu_axi_ctrl.sv
// Directed bench for arm_cpu_axi_ctrl: register access, IMEM loading,
// write-channel ordering/back-pressure, core reset, run/step/halt.
module tb_arm_cpu_axi_ctrl;
  logic        aclk, aresetn;
  logic        cpu_run, cpu_rst_n, imem_we, cpu_halted;
  logic [9:0]  imem_waddr;
  logic [31:0] imem_wdata, cpu_pc;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int bv_cyc = 0;
  int rst_low_cnt = 0;
  int run_hi_cnt = 0;
  logic [41:0] exp_q[$];
  logic [41:0] got_q[$];

  arm_cpu_axi_ctrl_if #(.ADDR_W(5), .DATA_W(32)) axi ();

  arm_cpu_axi_ctrl #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .IMEM_AW(10)) dut (
    .ACLK(aclk), .ARESETN(aresetn), .s_axi(axi.slave),
    .cpu_run(cpu_run), .cpu_rst_n(cpu_rst_n), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_pc(cpu_pc), .cpu_halted(cpu_halted)
  );

  // Clock and cycle index
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end
  always @(posedge aclk) cyc <= cyc + 1;

  // Passive monitor on the falling edge
  always @(negedge aclk) begin
    if (imem_we) got_q.push_back({imem_waddr, imem_wdata});
    if (!cpu_rst_n) rst_low_cnt <= rst_low_cnt + 1;
    if (cpu_run) run_hi_cnt <= run_hi_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Completes a write whose AW/W valids are already driven
  task automatic finish_write(output logic [1:0] resp);
    int n;
    logic aw_f, w_f;
    n = 0;
    axi.S_AXI_BREADY = 1'b1;
    while ((axi.S_AXI_AWVALID || axi.S_AXI_WVALID) && n < 50) begin
      aw_f = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_f  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(negedge aclk);
      if (aw_f) axi.S_AXI_AWVALID = 1'b0;
      if (w_f)  axi.S_AXI_WVALID  = 1'b0;
      n++;
    end
    while (!axi.S_AXI_BVALID && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("wr_handshake_done", 64'(n < 50), 64'd1);
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    resp   = axi.S_AXI_BRESP;
    bv_cyc = cyc;
    @(negedge aclk);
    axi.S_AXI_BREADY = 1'b0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic [1:0] exp_resp, input string tag);
    logic [1:0] resp;
    @(negedge aclk);
    axi.S_AXI_AWADDR = addr;
    axi.S_AXI_WDATA = data;
    axi.S_AXI_WSTRB = strb;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID = 1'b1;
    finish_write(resp);
    check(tag, 64'(resp), 64'(exp_resp));
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    int n;
    logic ar_f;
    logic [33:0] got;
    @(negedge aclk);
    axi.S_AXI_ARADDR = addr;
    axi.S_AXI_ARVALID = 1'b1;
    axi.S_AXI_RREADY = 1'b1;
    n = 0;
    while (axi.S_AXI_ARVALID && n < 50) begin
      ar_f = axi.S_AXI_ARREADY;
      @(negedge aclk);
      if (ar_f) axi.S_AXI_ARVALID = 1'b0;
      n++;
    end
    while (!axi.S_AXI_RVALID && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("rd_handshake_done", 64'(n < 50), 64'd1);
    got = {axi.S_AXI_RRESP, axi.S_AXI_RDATA};
    check(tag, 64'(got), {30'd0, 2'b00, exp});
    @(negedge aclk);
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    int n, base_rst, base_run;
    logic [1:0] resp;
    aresetn = 1'b0;
    cpu_halted = 1'b0;
    cpu_pc = 32'h0000_1234;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b0;
    repeat (3) @(negedge aclk);

    // Reset state
    check("rst_handshake", 64'({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID,
                                axi.S_AXI_ARREADY, axi.S_AXI_RVALID}), 64'd0);
    check("rst_resp_data", 64'({axi.S_AXI_BRESP, axi.S_AXI_RRESP, axi.S_AXI_RDATA}), 64'd0);
    check("rst_core", 64'({cpu_run, cpu_rst_n, imem_we, imem_waddr, imem_wdata}), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("core_rst_after_1", 64'(cpu_rst_n), 64'd0);
    @(negedge aclk);
    check("core_rst_after_2", 64'(cpu_rst_n), 64'd1);

    // SCRATCH full and strobed writes
    wr(5'h14, 32'h0000_0001, 4'hF, 2'b00, "scratch_wr_bresp");
    rd(5'h14, 32'h0000_0001, "scratch_rd_1");
    wr(5'h14, 32'hDEAD_BEEF, 4'b0011, 2'b00, "scratch_strb_bresp");
    rd(5'h14, 32'h0000_BEEF, "scratch_rd_strb");

    // IMEM load with address wrap and masked data
    wr(5'h04, 32'h0000_03FF, 4'hF, 2'b00, "imem_addr_wr");
    rd(5'h04, 32'h0000_03FF, "imem_addr_rd");
    exp_q.push_back({10'h3FF, 32'hE3A0_0001});
    wr(5'h08, 32'hE3A0_0001, 4'hF, 2'b00, "imem_data_wr_0");
    exp_q.push_back({10'h000, 32'hE3A0_1002});
    wr(5'h08, 32'hE3A0_1002, 4'hF, 2'b00, "imem_data_wr_1");
    rd(5'h04, 32'h0000_0001, "imem_addr_wrapped");
    exp_q.push_back({10'h001, 32'h0000_00FF});
    wr(5'h08, 32'hFFFF_FFFF, 4'b0001, 2'b00, "imem_data_wr_masked");
    rd(5'h08, 32'h0000_00FF, "imem_data_readback");
    rd(5'h04, 32'h0000_0002, "imem_addr_after_3");
    check("imem_we_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("imem_write_beat", 64'(got_q[i]), 64'(exp_q[i]));

    // W two cycles ahead of AW, then B back-pressured
    @(negedge aclk);
    axi.S_AXI_WDATA = 32'h1234_5678;
    axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_WVALID = 1'b1;
    @(negedge aclk);
    check("w_early_ready", 64'(axi.S_AXI_WREADY), 64'd1);
    @(negedge aclk);
    axi.S_AXI_WVALID = 1'b0;
    check("w_ready_pulse", 64'(axi.S_AXI_WREADY), 64'd0);
    axi.S_AXI_AWADDR = 5'h14;
    axi.S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!axi.S_AXI_AWREADY && n < 20) begin @(negedge aclk); n++; end
    check("aw_late_ready", 64'(axi.S_AXI_AWREADY), 64'd1);
    @(negedge aclk);
    axi.S_AXI_AWVALID = 1'b0;
    n = 0;
    while (!axi.S_AXI_BVALID && n < 20) begin @(negedge aclk); n++; end
    check("b_rise", 64'(axi.S_AXI_BVALID), 64'd1);
    check("b_resp_okay", 64'(axi.S_AXI_BRESP), 64'd0);
    rd(5'h14, 32'h1234_5678, "scratch_single_update");
    axi.S_AXI_AWADDR = 5'h14;
    axi.S_AXI_WDATA = 32'hCAFE_F00D;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("b_hold_blocks_aw_w", 64'({axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}),
            64'(3'b100));
      @(negedge aclk);
    end
    finish_write(resp);
    check("queued_write_bresp", 64'(resp), 64'd0);
    rd(5'h14, 32'hCAFE_F00D, "scratch_after_queued");

    // CORE_RST together with RUN
    base_rst = rst_low_cnt;
    base_run = run_hi_cnt;
    wr(5'h00, 32'h0000_0003, 4'hF, 2'b00, "ctrl_core_rst_bresp");
    repeat (4) @(negedge aclk);
    check("core_rst_low_cycles", 64'(rst_low_cnt - base_rst), 64'd2);
    check("core_rst_no_run", 64'(run_hi_cnt - base_run), 64'd0);
    rd(5'h00, 32'h0, "ctrl_after_core_rst");

    // RUN, halt, STEP while halted, RUN while halted, STEP
    wr(5'h00, 32'h0000_0001, 4'hF, 2'b00, "ctrl_run_bresp");
    rd(5'h0C, 32'h0000_0001, "status_running");
    cpu_halted = 1'b1;
    @(negedge aclk);
    check("halt_stops_run", 64'(cpu_run), 64'd0);
    rd(5'h0C, 32'h0000_0002, "status_halted");
    base_run = run_hi_cnt;
    wr(5'h00, 32'h0000_0004, 4'hF, 2'b00, "step_halted_bresp");
    repeat (3) @(negedge aclk);
    check("step_ignored_halted", 64'(run_hi_cnt - base_run), 64'd0);
    base_run = run_hi_cnt;
    wr(5'h00, 32'h0000_0001, 4'hF, 2'b00, "run_halted_bresp");
    repeat (3) @(negedge aclk);
    check("run_while_halted_1cyc", 64'(run_hi_cnt - base_run), 64'd1);
    cpu_halted = 1'b0;
    base_run = run_hi_cnt;
    wr(5'h00, 32'h0000_0004, 4'hF, 2'b00, "step_bresp");
    repeat (3) @(negedge aclk);
    check("step_one_cycle", 64'(run_hi_cnt - base_run), 64'd1);

    // Read-only and reserved offsets
    wr(5'h0C, 32'hFFFF_FFFF, 4'hF, 2'b10, "status_wr_slverr");
    rd(5'h0C, 32'h0, "status_unchanged");
    wr(5'h10, 32'hFFFF_FFFF, 4'hF, 2'b10, "pc_wr_slverr");
    rd(5'h10, 32'h0000_1234, "pc_rd");
    wr(5'h1C, 32'hFFFF_FFFF, 4'hF, 2'b10, "rsvd_wr_slverr");
    rd(5'h1C, 32'h0, "rsvd_rd");

`ifdef ARM_CTRL_CYCLE_CNT_EN
    wr(5'h00, 32'h0000_0002, 4'hF, 2'b00, "cnt_clear_bresp");
    wr(5'h00, 32'h0000_0001, 4'hF, 2'b00, "cnt_run_bresp");
    n = bv_cyc;
    while (cyc < n + 9) @(negedge aclk);
    cpu_halted = 1'b1;
    @(negedge aclk);
    cpu_halted = 1'b0;
    rd(5'h18, 32'd10, "cycle_cnt_10");
    wr(5'h18, 32'h0000_0005, 4'hF, 2'b10, "cycle_wr_slverr");
    rd(5'h18, 32'd10, "cycle_cnt_unchanged");
`else
    rd(5'h18, 32'h0, "cycle_absent_rd");
    wr(5'h18, 32'h0000_0005, 4'hF, 2'b10, "cycle_wr_slverr");
`endif

    repeat (2) @(negedge aclk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
